srl_tap_delay: RTL and testbench

- Parametrised variable-length delay line built on a shift-register chain: WIDTH-bit data, up to DEPTH stages, runtime-selectable tap.
- Successor to the single-bit-per-lane variable-tap SRL pattern. Adds:
  - a fill tracker with an output-valid flag
  - a synchronous clear that does not touch storage
  - an optional registered output stage
- Storage carries no reset, so synthesis maps the chain onto SRL primitives. Used as a programmable pipeline delay in the architecture tests.

---
 rtl/srl_tap_delay_if.sv | 28 ++
 rtl/srl_tap_chain.sv | 35 +++
 rtl/srl_tap_delay.sv | 81 ++++++++
 tb/tb_srl_tap_delay.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/srl_tap_delay_if.sv
// Bus bundle for srl_tap_delay: shift control, tap select, data in and the
// masked tap output with its fill status.
interface srl_tap_delay_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(DEPTH + 1);

  logic             en;
  logic             clr;
  logic [LW-1:0]    len;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [FW-1:0]    fill;

  // Master drives the delay line, slave is the delay line itself.
  modport master (
    output en, clr, len, din,
    input  dout, dout_valid, fill
  );

  modport slave (
    input  en, clr, len, din,
    output dout, dout_valid, fill
  );
endinterface

// File: rtl/srl_tap_chain.sv
// Reset-free shift chain with a runtime tap mux. Kept free of any reset or
// clear so synthesis can map the whole chain onto SRL primitives.
module srl_tap_chain #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned LW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [LW-1:0]    len,
  output logic [WIDTH-1:0] tap
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per enabled edge; storage deliberately has no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      stage_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Tap select; out-of-range len (non power-of-2 depth) clamps to the last stage.
  always_comb begin
    tap = stage_q[DEPTH-1];
    if (32'(len) < DEPTH) begin
      tap = stage_q[len];
    end
  end

endmodule

// File: rtl/srl_tap_delay.sv
// Programmable delay line: SRL chain plus fill tracking, output masking until
// the selected tap holds fresh data, and an optional output register.
module srl_tap_delay #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  srl_tap_delay_if.slave   bus
);

  localparam int unsigned LW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] tap;
  logic [FW-1:0]    fill_d, fill_q;
  logic             valid_int;
  logic [WIDTH-1:0] dout_int;

  srl_tap_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chain (
    .clk (clk),
    .en  (bus.en),
    .din (bus.din),
    .len (bus.len),
    .tap (tap)
  );

  // Fill next-state: clear wins, but a shift in the same cycle counts as one word.
  always_comb begin
    fill_d = fill_q;
    if (bus.clr) begin
      fill_d = bus.en ? FW'(1) : '0;
    end else if (bus.en && (fill_q != FW'(DEPTH))) begin
      fill_d = fill_q + FW'(1);
    end
  end

  // Fill counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  // Tap is only trusted once more words have been written than its index.
  always_comb begin
    valid_int = (fill_q > FW'(bus.len));
    dout_int  = valid_int ? tap : '0;
  end

  assign bus.fill = fill_q;

  if (REG_OUT) begin : g_reg_out
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    // Output register samples every cycle, independent of the shift enable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        dout_q  <= dout_int;
        valid_q <= valid_int;
      end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
  end else begin : g_comb_out
    assign bus.dout       = dout_int;
    assign bus.dout_valid = valid_int;
  end

endmodule

// File: tb/tb_srl_tap_delay.sv
// Directed bench: one combinational-output and one registered-output instance
// driven by identical stimulus, checked against hand-derived values.
module tb_srl_tap_delay;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  srl_tap_delay_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  srl_tap_delay_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

  assign bus1.en  = bus0.en;
  assign bus1.clr = bus0.clr;
  assign bus1.len = bus0.len;
  assign bus1.din = bus0.din;

  srl_tap_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REG_OUT(1'b0)) u_dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  srl_tap_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REG_OUT(1'b1)) u_dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, np, exp_fill;

    rst_n     = 1'b0;
    bus0.en   = 1'b0;
    bus0.clr  = 1'b0;
    bus0.len  = '0;
    bus0.din  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_fill",     32'(bus0.fill), 0);
    check("rst_valid",    32'(bus0.dout_valid), 0);
    check("rst_dout",     32'(bus0.dout), 0);
    check("rst_reg_valid", 32'(bus1.dout_valid), 0);
    check("rst_reg_dout", 32'(bus1.dout), 0);
    rst_n = 1'b1;

    // Steady shift with len=3: first word appears after the 4th enabled edge.
    bus0.en  = 1'b1;
    bus0.len = 4'd3;
    for (int k = 1; k <= 20; k++) begin
      bus0.din = 8'(k);
      step();
      exp_fill = (k > 16) ? 16 : k;
      check("s1_fill",  32'(bus0.fill), 32'(exp_fill));
      check("s1_valid", 32'(bus0.dout_valid), (k >= 4) ? 1 : 0);
      check("s1_dout",  32'(bus0.dout), (k >= 4) ? 32'(k - 3) : 0);
      check("s1_reg_valid", 32'(bus1.dout_valid), (k >= 5) ? 1 : 0);
      check("s1_reg_dout",  32'(bus1.dout), (k >= 5) ? 32'(k - 4) : 0);
    end

    // Clear, then enable gating with len=2: enabled words are 100,102,104,...
    bus0.en  = 1'b0;
    bus0.clr = 1'b1;
    step();
    bus0.clr = 1'b0;
    check("s2_clr_fill", 32'(bus0.fill), 0);
    bus0.len = 4'd2;
    for (int j = 0; j < 12; j++) begin
      bus0.en  = (j % 2 == 0);
      bus0.din = 8'(100 + j);
      step();
      n  = j / 2 + 1;
      np = (j == 0) ? 0 : (j - 1) / 2 + 1;
      check("s2_fill",  32'(bus0.fill), 32'(n));
      check("s2_valid", 32'(bus0.dout_valid), (n >= 3) ? 1 : 0);
      check("s2_dout",  32'(bus0.dout), (n >= 3) ? 32'(100 + 2 * (n - 3)) : 0);
      check("s2_reg_dout", 32'(bus1.dout), (np >= 3) ? 32'(100 + 2 * (np - 3)) : 0);
    end

    // Fill with 0x10..0x1F, then sweep the tap with the chain frozen.
    bus0.en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus0.din = 8'(8'h10 + i);
      step();
    end
    bus0.en = 1'b0;
    check("s3_fill", 32'(bus0.fill), 16);
    for (int l = 0; l < 16; l++) begin
      bus0.len = 4'(l);
      #1;
      check("s3_comb_tap", 32'(bus0.dout), 32'(8'h1F - l));
      check("s3_comb_valid", 32'(bus0.dout_valid), 1);
      step();
      check("s3_reg_tap", 32'(bus1.dout), 32'(8'h1F - l));
    end

    // Clear without shift: outputs masked, storage untouched.
    bus0.len = 4'd5;
    bus0.clr = 1'b1;
    step();
    bus0.clr = 1'b0;
    check("s4_clr_fill",  32'(bus0.fill), 0);
    check("s4_clr_valid", 32'(bus0.dout_valid), 0);
    check("s4_clr_dout",  32'(bus0.dout), 0);
    step();
    check("s4_clr_reg_valid", 32'(bus1.dout_valid), 0);
    check("s4_clr_reg_dout",  32'(bus1.dout), 0);
    bus0.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus0.din = 8'(8'h40 + i);
      step();
      check("s4_refill_valid", 32'(bus0.dout_valid), (i == 5) ? 1 : 0);
    end
    check("s4_refill_dout", 32'(bus0.dout), 32'h40);

    // Clear with shift: the new word counts immediately.
    bus0.clr = 1'b1;
    bus0.len = 4'd0;
    bus0.din = 8'h77;
    step();
    bus0.clr = 1'b0;
    check("s4_clren_fill",  32'(bus0.fill), 1);
    check("s4_clren_valid", 32'(bus0.dout_valid), 1);
    check("s4_clren_dout",  32'(bus0.dout), 32'h77);

    // Async reset between edges while valid.
    bus0.din = 8'h78;
    step();
    check("s5_pre_valid", 32'(bus0.dout_valid), 1);
    check("s5_pre_reg_valid", 32'(bus1.dout_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_rst_fill",      32'(bus0.fill), 0);
    check("s5_rst_valid",     32'(bus0.dout_valid), 0);
    check("s5_rst_dout",      32'(bus0.dout), 0);
    check("s5_rst_reg_valid", 32'(bus1.dout_valid), 0);
    check("s5_rst_reg_dout",  32'(bus1.dout), 0);
    rst_n = 1'b1;

    // Refill after reset behaves like the first run.
    bus0.len = 4'd3;
    for (int k = 1; k <= 6; k++) begin
      bus0.din = 8'(k);
      step();
      check("s5_refill_valid", 32'(bus0.dout_valid), (k >= 4) ? 1 : 0);
      check("s5_refill_dout",  32'(bus0.dout), (k >= 4) ? 32'(k - 3) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
